// File: rtl/byte_serializer_pkg.sv
// Shared types and constant helpers for the byte serializer.
package byte_serializer_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_e;

    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return r;
    endfunction

    // Counter width that never collapses to zero bits.
    function automatic int cnt_w(input int v);
        return (clog2(v) < 1) ? 1 : clog2(v);
    endfunction

endpackage

// File: rtl/byte_serializer_if.sv
// Load handshake plus serial output bundle of the byte serializer.
interface byte_serializer_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] data_in;
    logic                  load_valid;
    logic                  load_ready;
    logic                  ser_out;
    logic                  ser_valid;
    logic                  ser_last;
    logic                  busy;

    modport master (
        output data_in, load_valid,
        input  load_ready, ser_out, ser_valid, ser_last, busy
    );

    modport slave (
        input  data_in, load_valid,
        output load_ready, ser_out, ser_valid, ser_last, busy
    );
endinterface

// File: rtl/byte_serializer_bit_tick_counter.sv
// Bit-period timer: tick_o marks the last clk cycle of each serial bit.
module bit_tick_counter
    import byte_serializer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tick_o
);
    localparam int            CW   = cnt_w(CLKS_PER_BIT);
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!run_i)       cnt_d = '0;
        else if (tick_o)  cnt_d = '0;
        else              cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign tick_o = (CLKS_PER_BIT == 1) ? 1'b1 : (cnt_q == LAST);
endmodule

// File: rtl/byte_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word load, 1-bit stream with
// bit-valid strobe and last-bit flag; back-to-back words run with no gap.
module byte_serializer
    import byte_serializer_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter bit MSB_FIRST    = 1'b1,
    parameter int CLKS_PER_BIT = 1
) (
    input  logic              clk,
    input  logic              rst,
    byte_serializer_if.slave  bus
);
    localparam int            BW       = cnt_w(DATA_WIDTH);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
    logic                  tick;
    logic                  last_bit;
    logic                  word_end;
    logic                  accept;

    bit_tick_counter #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk    (clk),
        .rst    (rst),
        .run_i  (state_q == ST_SHIFT),
        .tick_o (tick)
    );

    assign last_bit = (bit_cnt_q == LAST_BIT);
    assign word_end = (state_q == ST_SHIFT) && last_bit && tick;
    // Ready depends on registered state only, so no path from load_valid.
    assign bus.load_ready = (state_q == ST_IDLE) || word_end;
    assign accept         = bus.load_valid && bus.load_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (accept)   state_d = ST_SHIFT;
            ST_SHIFT: if (word_end) state_d = accept ? ST_SHIFT : ST_IDLE;
            default:                state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        if (accept) begin
            shift_d   = bus.data_in;
            bit_cnt_d = '0;
        end else if (word_end) begin
            bit_cnt_d = '0;
        end else if (state_q == ST_SHIFT && tick) begin
            shift_d   = MSB_FIRST ? {shift_q[DATA_WIDTH-2:0], 1'b0}
                                  : {1'b0, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + 1'b1;
        end
    end

    always_comb begin
        bus.ser_valid = (state_q == ST_SHIFT);
        bus.busy      = (state_q == ST_SHIFT);
        bus.ser_last  = (state_q == ST_SHIFT) && last_bit;
        bus.ser_out   = 1'b0;
        if (state_q == ST_SHIFT)
            bus.ser_out = MSB_FIRST ? shift_q[DATA_WIDTH-1] : shift_q[0];
    end
endmodule

// File: tb/tb_byte_serializer.sv
// Directed bench: default MSB-first instance plus an LSB-first, 3-clk/bit instance.
module tb_byte_serializer;
    logic clk;
    logic rst;
    int   n_asserts;
    int   n_fail;

    byte_serializer_if #(.DATA_WIDTH(8)) if0 ();
    byte_serializer_if #(.DATA_WIDTH(8)) if1 ();

    byte_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1), .CLKS_PER_BIT(1)) u0 (
        .clk (clk), .rst (rst), .bus (if0.slave)
    );
    byte_serializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0), .CLKS_PER_BIT(3)) u1 (
        .clk (clk), .rst (rst), .bus (if1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Observed vector order: {ser_out, ser_valid, ser_last, busy, load_ready}
    task automatic test_reset();
        logic [4:0] o0, o1;
        repeat (2) step();
        o0 = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
        o1 = {if1.ser_out, if1.ser_valid, if1.ser_last, if1.busy, if1.load_ready};
        n_asserts++;
        if (o0 !== 5'b00001) begin n_fail++; $display("FAIL reset_u0 got %b want 00001", o0); end
        n_asserts++;
        if (o1 !== 5'b00001) begin n_fail++; $display("FAIL reset_u1 got %b want 00001", o1); end
        rst = 1'b0;
        // start a word on both, then reset asynchronously between edges
        if0.data_in = 8'hFF; if0.load_valid = 1'b1;
        if1.data_in = 8'hFF; if1.load_valid = 1'b1;
        step();
        if0.load_valid = 1'b0; if1.load_valid = 1'b0;
        step();
        n_asserts++;
        if (if0.busy !== 1'b1 || if1.busy !== 1'b1) begin
            n_fail++; $display("FAIL reset_prebusy got %b%b want 11", if0.busy, if1.busy);
        end
        #2 rst = 1'b1;
        #1;
        o0 = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
        o1 = {if1.ser_out, if1.ser_valid, if1.ser_last, if1.busy, if1.load_ready};
        n_asserts++;
        if (o0 !== 5'b00001) begin n_fail++; $display("FAIL async_reset_u0 got %b want 00001", o0); end
        n_asserts++;
        if (o1 !== 5'b00001) begin n_fail++; $display("FAIL async_reset_u1 got %b want 00001", o1); end
        step();
        rst = 1'b0;
        step();
    endtask

    task automatic test_single();
        logic [7:0] w;
        logic [4:0] o, e;
        w = 8'hA5;
        if0.data_in = w; if0.load_valid = 1'b1;
        step();
        if0.load_valid = 1'b0; if0.data_in = 8'h00;
        for (int i = 0; i < 8; i++) begin
            o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
            e = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
            n_asserts++;
            if (o !== e) begin n_fail++; $display("FAIL single bit%0d got %b want %b", i, o, e); end
            step();
        end
        o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
        n_asserts++;
        if (o !== 5'b00001) begin n_fail++; $display("FAIL single_idle got %b want 00001", o); end
    endtask

    task automatic test_lsb_cpb3();
        logic [4:0] o, e;
        if1.data_in = 8'h01; if1.load_valid = 1'b1;
        step();
        if1.load_valid = 1'b0; if1.data_in = 8'h00;
        for (int c = 0; c < 24; c++) begin
            o = {if1.ser_out, if1.ser_valid, if1.ser_last, if1.busy, if1.load_ready};
            e = {(c < 3), 1'b1, (c >= 21), 1'b1, (c == 23)};
            n_asserts++;
            if (o !== e) begin n_fail++; $display("FAIL lsb_cpb3 cyc%0d got %b want %b", c, o, e); end
            step();
        end
        o = {if1.ser_out, if1.ser_valid, if1.ser_last, if1.busy, if1.load_ready};
        n_asserts++;
        if (o !== 5'b00001) begin n_fail++; $display("FAIL lsb_cpb3_idle got %b want 00001", o); end
    endtask

    task automatic test_back_to_back();
        logic [4:0] o, e;
        if0.data_in = 8'hFF; if0.load_valid = 1'b1;
        step();
        if0.data_in = 8'h00;
        for (int c = 0; c < 16; c++) begin
            o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
            e = {(c < 8), 1'b1, (c == 7 || c == 15), 1'b1, (c == 7 || c == 15)};
            n_asserts++;
            if (o !== e) begin n_fail++; $display("FAIL b2b cyc%0d got %b want %b", c, o, e); end
            step();
            if (c == 7) if0.load_valid = 1'b0;
        end
        o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
        n_asserts++;
        if (o !== 5'b00001) begin n_fail++; $display("FAIL b2b_idle got %b want 00001", o); end
    endtask

    task automatic test_stall();
        logic [7:0] w;
        logic [4:0] o, e;
        w = 8'h96;
        if0.data_in = w; if0.load_valid = 1'b1;
        step();
        for (int c = 0; c < 8; c++) begin
            if (c < 7) begin
                if0.data_in    = 8'($urandom);
                if0.load_valid = 1'($urandom_range(0, 1));
            end else begin
                if0.load_valid = 1'b0;
            end
            #1;
            o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
            e = {w[7-c], 1'b1, (c == 7), 1'b1, (c == 7)};
            n_asserts++;
            if (o !== e) begin n_fail++; $display("FAIL stall bit%0d got %b want %b", c, o, e); end
            step();
        end
        o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
        n_asserts++;
        if (o !== 5'b00001) begin n_fail++; $display("FAIL stall_idle got %b want 00001", o); end
    endtask

    task automatic test_reset_midword();
        logic [7:0] w;
        logic [4:0] o, e;
        w = 8'hC3;
        if0.data_in = w; if0.load_valid = 1'b1;
        step();
        if0.load_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            n_asserts++;
            if (if0.ser_out !== w[7-c]) begin
                n_fail++; $display("FAIL rst_mid_pre bit%0d got %b want %b", c, if0.ser_out, w[7-c]);
            end
            step();
        end
        #2 rst = 1'b1;
        #1;
        o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
        n_asserts++;
        if (o !== 5'b00001) begin n_fail++; $display("FAIL rst_mid_drop got %b want 00001", o); end
        step();
        rst = 1'b0;
        step();
        w = 8'h3C;
        if0.data_in = w; if0.load_valid = 1'b1;
        step();
        if0.load_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
            e = {w[7-i], 1'b1, (i == 7), 1'b1, (i == 7)};
            n_asserts++;
            if (o !== e) begin n_fail++; $display("FAIL rst_mid_new bit%0d got %b want %b", i, o, e); end
            step();
        end
        o = {if0.ser_out, if0.ser_valid, if0.ser_last, if0.busy, if0.load_ready};
        n_asserts++;
        if (o !== 5'b00001) begin n_fail++; $display("FAIL rst_mid_idle got %b want 00001", o); end
    endtask

    initial begin
        n_asserts = 0;
        n_fail    = 0;
        rst = 1'b1;
        if0.data_in = '0; if0.load_valid = 1'b0;
        if1.data_in = '0; if1.load_valid = 1'b0;
        test_reset();
        test_single();
        test_lsb_cpb3();
        test_back_to_back();
        test_stall();
        test_reset_midword();
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
